// File: rtl/mips_pkg.sv
// Shared types for the register-file write-back arbiter.
// Source select and arbiter state encodings live here.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_LLU
    } wb_src_e;

    typedef enum logic {
        NORMAL,
        STARVED
    } arb_state_e;

endpackage

// File: rtl/llu_result_fifo.sv
// Small FIFO of long-latency results with per-entry valid bits.
// Entries matching the kill address are invalidated in place.
module llu_result_fifo
    import mips_pkg::*;
#(
    parameter int DW    = REG_DATA_W,
    parameter int AW    = REG_ADDR_W,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_addr,
    output logic          head_present,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && addr_q[i] == kill_addr) begin
                valid_d[i] = 1'b0;
            end
        end
        if (pop) begin
            valid_d[rd_q] = 1'b0;
            rd_d          = rd_q + PW'(1);
        end
        // The incoming entry is never killed: it is older than nothing queued.
        if (push) begin
            valid_d[wr_q] = 1'b1;
            addr_d[wr_q]  = push_addr;
            data_d[wr_q]  = push_data;
            wr_d          = wr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head_present = (count_q != '0);
    assign head_valid   = head_present & valid_q[rd_q];
    assign head_addr    = addr_q[rd_q];
    assign head_data    = data_q[rd_q];
    assign full         = (count_q == CW'(DEPTH));
    assign count        = count_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: pipeline first, buffered LLU
// results drained when idle or when starvation forces a stall.
module rf_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W       = REG_DATA_W,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [DATA_W-1:0]          final_result,
    input  logic [ADDR_W-1:0]          write_reg_out,
    input  logic                       reg_write_final,
    input  logic                       llu_valid,
    output logic                       llu_ready,
    input  logic [ADDR_W-1:0]          llu_addr,
    input  logic [DATA_W-1:0]          llu_data,
    output logic                       wb_stall_req,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       reg_write_to_file,
    output logic [ADDR_W-1:0]          reg_write_addr,
    output logic [DATA_W-1:0]          reg_write_data
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    wb_src_e           src;
    logic [AGE_W-1:0]  age_q, age_d;
    logic              stall_req_q, stall_req_d;
    logic              ready_en_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              pipe_req;
    logic              push, pop;
    logic              head_present, head_valid, full;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     count;

    assign pipe_req = reg_write_final & ~stall & (write_reg_out != '0);
    // Zero-address results are acknowledged but never stored.
    assign push     = llu_valid & llu_ready & (llu_addr != '0);

    llu_result_fifo #(
        .DW    (DATA_W),
        .AW    (ADDR_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .push         (push),
        .push_addr    (llu_addr),
        .push_data    (llu_data),
        .pop          (pop),
        .kill_en      (src == SRC_PIPE),
        .kill_addr    (write_reg_out),
        .head_present (head_present),
        .head_valid   (head_valid),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .full         (full),
        .count        (count)
    );

    always_comb begin
        src         = SRC_NONE;
        state_d     = state_q;
        stall_req_d = stall_req_q;
        age_d       = age_q;
        unique case (state_q)
            NORMAL: begin
                if (pipe_req) src = SRC_PIPE;
                else if (head_valid) src = SRC_LLU;
            end
            STARVED: begin
                if (head_valid) src = SRC_LLU;
            end
            default: src = SRC_NONE;
        endcase

        // Killed heads are dropped without taking the write port.
        pop = head_present & (~head_valid | (src == SRC_LLU));

        if (pop || !head_valid) age_d = '0;
        else if (src != SRC_LLU) age_d = age_q + AGE_W'(1);

        unique case (state_q)
            NORMAL: begin
                if (age_d == AGE_W'(STARVE_LIMIT)) begin
                    state_d     = STARVED;
                    stall_req_d = 1'b1;
                end
            end
            STARVED: begin
                if (pop || !head_present) begin
                    state_d     = NORMAL;
                    stall_req_d = 1'b0;
                end
            end
            default: state_d = NORMAL;
        endcase

        we_d    = (src != SRC_NONE);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (src)
            SRC_PIPE: begin
                waddr_d = write_reg_out;
                wdata_d = final_result;
            end
            SRC_LLU: begin
                waddr_d = head_addr;
                wdata_d = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= NORMAL;
            age_q       <= '0;
            stall_req_q <= 1'b0;
            ready_en_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            age_q       <= age_d;
            stall_req_q <= stall_req_d;
            ready_en_q  <= 1'b1;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign llu_ready         = ready_en_q & ~full;
    assign wb_stall_req      = stall_req_q;
    assign fifo_count        = count;
    assign reg_write_to_file = we_q;
    assign reg_write_addr    = waddr_q;
    assign reg_write_data    = wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for the register-file write-back arbiter.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] final_result;
    logic [4:0]  write_reg_out;
    logic        reg_write_final;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_addr;
    logic [31:0] llu_data;
    logic        wb_stall_req;
    logic [1:0]  fifo_count;
    logic        reg_write_to_file;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .final_result      (final_result),
        .write_reg_out     (write_reg_out),
        .reg_write_final   (reg_write_final),
        .llu_valid         (llu_valid),
        .llu_ready         (llu_ready),
        .llu_addr          (llu_addr),
        .llu_data          (llu_data),
        .wb_stall_req      (wb_stall_req),
        .fifo_count        (fifo_count),
        .reg_write_to_file (reg_write_to_file),
        .reg_write_addr    (reg_write_addr),
        .reg_write_data    (reg_write_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall           = 1'b0;
        reg_write_final = 1'b0;
        write_reg_out   = 5'd0;
        final_result    = 32'h0;
        llu_valid       = 1'b0;
        llu_addr        = 5'd0;
        llu_data        = 32'h0;
    endtask

    task automatic test_reset();
        rst             = 1'b0;
        idle_inputs();
        llu_valid       = 1'b1;
        llu_addr        = 5'd3;
        reg_write_final = 1'b1;
        write_reg_out   = 5'd2;
        tick();
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data, wb_stall_req,
             fifo_count, llu_ready} !== 42'h0) begin
            errs++;
            $display("FAIL reset_outputs: got we=%b a=%0d d=%h st=%b cnt=%0d rdy=%b want all 0",
                     reg_write_to_file, reg_write_addr, reg_write_data,
                     wb_stall_req, fifo_count, llu_ready);
        end
        idle_inputs();
        rst = 1'b1;
        vec++;
        if (llu_ready !== 1'b0) begin
            errs++;
            $display("FAIL ready_at_release: got %b want 0", llu_ready);
        end
        tick();
        vec++;
        if ({llu_ready, fifo_count} !== {1'b1, 2'd0}) begin
            errs++;
            $display("FAIL ready_after_release: got rdy=%b cnt=%0d want 1 0",
                     llu_ready, fifo_count);
        end
    endtask

    task automatic test_pipe_only();
        reg_write_final = 1'b1;
        write_reg_out   = 5'd5;
        final_result    = 32'hDEADBEEF;
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data} !==
            {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL pipe_write: got %b %0d %h want 1 5 deadbeef",
                     reg_write_to_file, reg_write_addr, reg_write_data);
        end
        write_reg_out = 5'd0;
        final_result  = 32'h1234;
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data} !==
            {1'b0, 5'd5, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL pipe_r0_nowrite: got %b %0d %h want 0 5 deadbeef",
                     reg_write_to_file, reg_write_addr, reg_write_data);
        end
        idle_inputs();
    endtask

    task automatic test_llu_idle();
        llu_valid = 1'b1;
        llu_addr  = 5'd7;
        llu_data  = 32'h12;
        tick();
        idle_inputs();
        vec++;
        if ({reg_write_to_file, fifo_count} !== {1'b0, 2'd1}) begin
            errs++;
            $display("FAIL llu_n1: got we=%b cnt=%0d want 0 1",
                     reg_write_to_file, fifo_count);
        end
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data, fifo_count} !==
            {1'b1, 5'd7, 32'h12, 2'd0}) begin
            errs++;
            $display("FAIL llu_n2: got %b %0d %h cnt=%0d want 1 7 12 0",
                     reg_write_to_file, reg_write_addr, reg_write_data, fifo_count);
        end
        // zero-address result: accepted, never stored or written
        llu_valid = 1'b1;
        llu_addr  = 5'd0;
        llu_data  = 32'h77;
        tick();
        idle_inputs();
        vec++;
        if (fifo_count !== 2'd0) begin
            errs++;
            $display("FAIL llu_r0_discard: got cnt=%0d want 0", fifo_count);
        end
        tick();
        vec++;
        if (reg_write_to_file !== 1'b0) begin
            errs++;
            $display("FAIL llu_r0_nowrite: got we=%b want 0", reg_write_to_file);
        end
    endtask

    task automatic test_fill_and_drain();
        reg_write_final = 1'b1;
        write_reg_out   = 5'd3;
        final_result    = 32'hAAA;
        llu_valid       = 1'b1;
        llu_addr        = 5'd10;
        llu_data        = 32'h100;
        tick();
        llu_addr = 5'd11;
        llu_data = 32'h101;
        tick();
        llu_valid = 1'b0;
        vec++;
        if ({fifo_count, llu_ready, reg_write_addr} !== {2'd2, 1'b0, 5'd3}) begin
            errs++;
            $display("FAIL fifo_full: got cnt=%0d rdy=%b a=%0d want 2 0 3",
                     fifo_count, llu_ready, reg_write_addr);
        end
        reg_write_final = 1'b0;
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data, fifo_count, llu_ready} !==
            {1'b1, 5'd10, 32'h100, 2'd1, 1'b1}) begin
            errs++;
            $display("FAIL drain_first: got %b %0d %h cnt=%0d rdy=%b want 1 10 100 1 1",
                     reg_write_to_file, reg_write_addr, reg_write_data,
                     fifo_count, llu_ready);
        end
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data, fifo_count} !==
            {1'b1, 5'd11, 32'h101, 2'd0}) begin
            errs++;
            $display("FAIL drain_second: got %b %0d %h cnt=%0d want 1 11 101 0",
                     reg_write_to_file, reg_write_addr, reg_write_data, fifo_count);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        reg_write_final = 1'b1;
        write_reg_out   = 5'd4;
        final_result    = 32'h40;
        llu_valid       = 1'b1;
        llu_addr        = 5'd12;
        llu_data        = 32'h55;
        tick();
        llu_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            final_result = 32'h41 + 32'(k);
            tick();
            vec++;
            if ({wb_stall_req, reg_write_to_file, reg_write_addr, reg_write_data} !==
                {k == 3, 1'b1, 5'd4, 32'h41 + 32'(k)}) begin
                errs++;
                $display("FAIL starve_deny[%0d]: got st=%b we=%b a=%0d d=%h want st=%b 1 4 %h",
                         k, wb_stall_req, reg_write_to_file, reg_write_addr,
                         reg_write_data, k == 3, 32'h41 + 32'(k));
            end
        end
        tick();
        vec++;
        if ({wb_stall_req, reg_write_to_file, reg_write_addr, reg_write_data, fifo_count} !==
            {1'b0, 1'b1, 5'd12, 32'h55, 2'd0}) begin
            errs++;
            $display("FAIL starve_grant: got st=%b %b %0d %h cnt=%0d want 0 1 12 55 0",
                     wb_stall_req, reg_write_to_file, reg_write_addr,
                     reg_write_data, fifo_count);
        end
        tick();
        vec++;
        if ({wb_stall_req, reg_write_to_file, reg_write_addr, reg_write_data} !==
            {1'b0, 1'b1, 5'd4, 32'h44}) begin
            errs++;
            $display("FAIL starve_resume: got st=%b %b %0d %h want 0 1 4 44",
                     wb_stall_req, reg_write_to_file, reg_write_addr, reg_write_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_waw_kill();
        llu_valid = 1'b1;
        llu_addr  = 5'd9;
        llu_data  = 32'h99;
        tick();
        llu_valid       = 1'b0;
        reg_write_final = 1'b1;
        write_reg_out   = 5'd9;
        final_result    = 32'h999;
        tick();
        idle_inputs();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data} !==
            {1'b1, 5'd9, 32'h999}) begin
            errs++;
            $display("FAIL waw_pipe: got %b %0d %h want 1 9 999",
                     reg_write_to_file, reg_write_addr, reg_write_data);
        end
        tick();
        vec++;
        if ({reg_write_to_file, fifo_count} !== {1'b0, 2'd0}) begin
            errs++;
            $display("FAIL waw_drop: got we=%b cnt=%0d want 0 0",
                     reg_write_to_file, fifo_count);
        end
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_data} !== {1'b0, 32'h999}) begin
            errs++;
            $display("FAIL waw_nostale: got we=%b d=%h want 0 999",
                     reg_write_to_file, reg_write_data);
        end
    endtask

    task automatic test_stall_gating();
        llu_valid = 1'b1;
        llu_addr  = 5'd14;
        llu_data  = 32'hE0;
        tick();
        llu_valid       = 1'b0;
        stall           = 1'b1;
        reg_write_final = 1'b1;
        write_reg_out   = 5'd15;
        final_result    = 32'hF0;
        vec++;
        if ({reg_write_to_file, fifo_count} !== {1'b0, 2'd1}) begin
            errs++;
            $display("FAIL stall_queued: got we=%b cnt=%0d want 0 1",
                     reg_write_to_file, fifo_count);
        end
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data} !==
            {1'b1, 5'd14, 32'hE0}) begin
            errs++;
            $display("FAIL stall_llu_write: got %b %0d %h want 1 14 e0",
                     reg_write_to_file, reg_write_addr, reg_write_data);
        end
        tick();
        vec++;
        if (reg_write_to_file !== 1'b0) begin
            errs++;
            $display("FAIL stall_blocks_pipe: got we=%b want 0", reg_write_to_file);
        end
        stall = 1'b0;
        tick();
        vec++;
        if ({reg_write_to_file, reg_write_addr, reg_write_data} !==
            {1'b1, 5'd15, 32'hF0}) begin
            errs++;
            $display("FAIL unstall_pipe: got %b %0d %h want 1 15 f0",
                     reg_write_to_file, reg_write_addr, reg_write_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midop();
        llu_valid       = 1'b1;
        llu_addr        = 5'd20;
        llu_data        = 32'h20;
        reg_write_final = 1'b1;
        write_reg_out   = 5'd21;
        final_result    = 32'h21;
        tick();
        idle_inputs();
        rst = 1'b0;
        #1;
        vec++;
        if ({reg_write_to_file, reg_write_addr, fifo_count, llu_ready} !==
            {1'b0, 5'd0, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL midop_reset: got we=%b a=%0d cnt=%0d rdy=%b want 0 0 0 0",
                     reg_write_to_file, reg_write_addr, fifo_count, llu_ready);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        vec++;
        if ({reg_write_to_file, fifo_count, llu_ready} !== {1'b0, 2'd0, 1'b1}) begin
            errs++;
            $display("FAIL midop_after: got we=%b cnt=%0d rdy=%b want 0 0 1",
                     reg_write_to_file, fifo_count, llu_ready);
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_llu_idle();
        test_fill_and_drain();
        test_starvation();
        test_waw_kill();
        test_stall_gating();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
